// File: rtl/lfsr_prbs_ctrl.sv
// Fibonacci-LFSR PRBS generator with a tick divider, a debounced step button, seed loading,
// lock-up recovery and period detection. It drives two 4-bit digits for the 7-segment decoders.
module lfsr_prbs_ctrl #(
   parameter int               WIDTH   = 8,
   parameter logic [WIDTH-1:0] TAPS    = WIDTH'(8'hB8),
   parameter logic [WIDTH-1:0] SEED    = WIDTH'(1),
   parameter int               DIV     = 5000000,
   parameter int               DEB_CYC = 16
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic [1:0]       i_mode,
   input  logic             i_btn,
   input  logic             i_seed_load,
   input  logic [WIDTH-1:0] i_seed_in,
   output logic [WIDTH-1:0] o_prbs_output,
   output logic             o_valid,
   output logic             o_period_done,
   output logic [3:0]       o_digit_lo,
   output logic [3:0]       o_digit_hi
);

   localparam int DW  = (DIV > 2) ? $clog2(DIV) : 1;
   localparam int DBW = $clog2(DEB_CYC + 1);

   typedef enum logic [1:0] {S_HOLD, S_RUN, S_STEP} fsm_t;

   fsm_t             r_fsm;
   logic [DW-1:0]    r_div_cnt;
   logic [1:0]       r_sync;
   logic [DBW-1:0]   r_deb_cnt;
   logic             r_deb_lvl;
   logic             r_deb_lvl_q;
   logic [WIDTH-1:0] r_state;
   logic [WIDTH-1:0] r_start;
   logic             r_valid;
   logic             r_period_done;

   logic             w_tick;
   logic             w_synced;
   logic             w_press;
   logic             w_fb;
   logic [WIDTH-1:0] w_next;
   logic [WIDTH-1:0] w_seed;
   logic             w_adv;

   assign w_tick   = (r_div_cnt == DW'(DIV - 1));
   assign w_synced = r_sync[1];
   assign w_press  = r_deb_lvl & ~r_deb_lvl_q;
   assign w_fb     = ^(r_state & TAPS);
   assign w_next   = {r_state[WIDTH-2:0], w_fb};
   assign w_seed   = (i_seed_in == '0) ? SEED : i_seed_in;
   assign w_adv    = ((r_fsm == S_RUN) && w_tick) || ((r_fsm == S_STEP) && w_press);

   // Mode register: the reserved encoding behaves as hold.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_fsm <= S_HOLD;
      end else begin
         case (i_mode)
            2'b01:   r_fsm <= S_RUN;
            2'b10:   r_fsm <= S_STEP;
            default: r_fsm <= S_HOLD;
         endcase
      end
   end

   // The divider runs freely in every mode so tick spacing does not depend on mode changes.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_div_cnt <= '0;
      end else if (w_tick) begin
         r_div_cnt <= '0;
      end else begin
         r_div_cnt <= r_div_cnt + DW'(1);
      end
   end

   // Any cycle in which the synced level agrees with the debounced level restarts the count.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_sync      <= '0;
         r_deb_cnt   <= '0;
         r_deb_lvl   <= 1'b0;
         r_deb_lvl_q <= 1'b0;
      end else begin
         r_sync      <= {r_sync[0], i_btn};
         r_deb_lvl_q <= r_deb_lvl;
         if (w_synced == r_deb_lvl) begin
            r_deb_cnt <= '0;
         end else if (r_deb_cnt == DBW'(DEB_CYC - 1)) begin
            r_deb_lvl <= w_synced;
            r_deb_cnt <= '0;
         end else begin
            r_deb_cnt <= r_deb_cnt + DBW'(1);
         end
      end
   end

   // Seed load wins over lock-up recovery, and both win over a normal advance.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state       <= SEED;
         r_start       <= SEED;
         r_valid       <= 1'b0;
         r_period_done <= 1'b0;
      end else begin
         r_valid       <= 1'b0;
         r_period_done <= 1'b0;
         if (i_seed_load) begin
            r_state <= w_seed;
            r_start <= w_seed;
         end else if (r_state == '0) begin
            r_state <= SEED;
         end else if (w_adv) begin
            r_state       <= w_next;
            r_valid       <= 1'b1;
            r_period_done <= (w_next == r_start);
         end
      end
   end

   assign o_prbs_output = r_state;
   assign o_valid       = r_valid;
   assign o_period_done = r_period_done;
   assign o_digit_lo    = r_state[3:0];
   assign o_digit_hi    = r_state[7:4];

endmodule

// File: tb/tb_lfsr_prbs_ctrl.sv
// Directed bench for lfsr_prbs_ctrl with WIDTH=8, TAPS=B8, SEED=01, DIV=4, DEB_CYC=16.
module tb_lfsr_prbs_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [1:0] mode = 2'b01;
   logic       btn = 1'b0;
   logic       seed_load = 1'b0;
   logic [7:0] seed_in = 8'h00;
   logic [7:0] prbs;
   logic       valid;
   logic       pdone;
   logic [3:0] dlo;
   logic [3:0] dhi;

   int n_tests = 0;
   int n_fail  = 0;

   lfsr_prbs_ctrl #(
      .WIDTH(8), .TAPS(8'hB8), .SEED(8'h01), .DIV(4), .DEB_CYC(16)
   ) dut (
      .i_clk(clk), .i_rst(rst), .i_mode(mode), .i_btn(btn),
      .i_seed_load(seed_load), .i_seed_in(seed_in),
      .o_prbs_output(prbs), .o_valid(valid), .o_period_done(pdone),
      .o_digit_lo(dlo), .o_digit_hi(dhi)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Returns the number of cycles until valid is seen (budget on timeout).
   task automatic wait_valid(input int budget, output int cyc);
      cyc = 0;
      do begin
         step();
         cyc++;
      end while (!valid && cyc < budget);
   endtask

   task automatic count_valid(input int n, output int vc);
      vc = 0;
      for (int i = 0; i < n; i++) begin
         step();
         if (valid) vc++;
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
   endtask

   logic [7:0] exp_seq [5] = '{8'h02, 8'h04, 8'h08, 8'h11, 8'h23};

   initial begin
      int         cyc;
      int         vc;
      int         pd_cnt;
      int         pd_bad;
      int         reps;
      logic [7:0] st;
      logic [255:0] seen;

      // 1: reset state, then free-run every DIV clocks
      step();
      chk("rst_prbs", prbs, 8'h01);
      chk("rst_valid", valid, 1'b0);
      chk("rst_pdone", pdone, 1'b0);
      rst = 1'b0;
      for (int i = 0; i < 5; i++) begin
         wait_valid(12, cyc);
         chk($sformatf("run_gap%0d", i), cyc, 4);
         chk($sformatf("run_val%0d", i), prbs, exp_seq[i]);
      end
      chk("digit_lo", dlo, 4'h3);
      chk("digit_hi", dhi, 4'h2);

      // 6: async reset at state 23 takes effect between edges
      #2;
      rst = 1'b1;
      #1;
      chk("arst_prbs", prbs, 8'h01);
      chk("arst_valid", valid, 1'b0);
      step();
      rst = 1'b0;
      wait_valid(12, cyc);
      chk("arst_gap", cyc, 4);
      chk("arst_next", prbs, 8'h02);

      // 2: full period from SEED
      do_reset();
      seen   = '0;
      seen[1] = 1'b1;
      pd_cnt = 0;
      pd_bad = 0;
      reps   = 0;
      for (int i = 0; i < 255; i++) begin
         wait_valid(12, cyc);
         if (!valid) break;
         st = prbs;
         if (pdone) pd_cnt++;
         if (pdone != (st == 8'h01)) pd_bad++;
         if (st != 8'h01 && seen[st]) reps++;
         seen[st] = 1'b1;
      end
      chk("period_back", prbs, 8'h01);
      chk("period_cnt", pd_cnt, 1);
      chk("period_flag", pd_bad, 0);
      chk("period_reps", reps, 0);

      // 3: single-step through a bouncing button
      mode = 2'b10;
      count_valid(3, vc);
      chk("step_enter", vc, 0);
      btn = 1'b1; count_valid(3, vc); cyc = vc;
      btn = 1'b0; count_valid(3, vc); cyc += vc;
      btn = 1'b1; count_valid(3, vc); cyc += vc;
      btn = 1'b0; count_valid(3, vc); cyc += vc;
      btn = 1'b1; count_valid(3, vc); cyc += vc;
      chk("bounce_none", cyc, 0);
      count_valid(30, vc);
      chk("press_once", vc, 1);
      chk("press_val", prbs, 8'h02);
      btn = 1'b0;
      count_valid(30, vc);
      chk("release_none", vc, 0);
      chk("release_val", prbs, 8'h02);

      // 4: seed load coincident with a tick
      mode = 2'b01;
      wait_valid(12, cyc);
      chk("rerun_val", prbs, 8'h04);
      repeat (3) step();
      seed_load = 1'b1;
      seed_in   = 8'h00;
      step();
      seed_load = 1'b0;
      chk("seed0_val", prbs, 8'h01);
      chk("seed0_valid", valid, 1'b0);
      chk("seed0_pdone", pdone, 1'b0);
      wait_valid(12, cyc);
      chk("seed0_gap", cyc, 4);
      chk("seed0_next", prbs, 8'h02);
      repeat (3) step();
      seed_load = 1'b1;
      seed_in   = 8'hA5;
      step();
      seed_load = 1'b0;
      chk("seedA5_val", prbs, 8'hA5);
      chk("seedA5_valid", valid, 1'b0);
      wait_valid(12, cyc);
      chk("seedA5_gap", cyc, 4);
      chk("seedA5_next", prbs, 8'h4A);

      // 5: hold ignores ticks and button presses
      mode = 2'b00;
      btn  = 1'b1;
      count_valid(25, vc);
      cyc = vc;
      btn = 1'b0;
      count_valid(15, vc);
      cyc += vc;
      chk("hold_valid", cyc, 0);
      chk("hold_val", prbs, 8'h4A);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
